// File: rtl/vfs_pkg.sv
// rtl/vfs_pkg.sv - shared types, vector constants and preset encodings for the vector fetch sequencer
package vfs_pkg;

    typedef enum logic [1:0] {
        VK_RESET,
        VK_NMI,
        VK_IRQ
    } vec_kind_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        DONE,
        ABORT
    } state_t;

    localparam logic [7:0] VEC_NMI_LO   = 8'hFA;
    localparam logic [7:0] VEC_NMI_HI   = 8'hFB;
    localparam logic [7:0] VEC_RESET_LO = 8'hFC;
    localparam logic [7:0] VEC_RESET_HI = 8'hFD;
    localparam logic [7:0] VEC_IRQ_LO   = 8'hFE;
    localparam logic [7:0] VEC_IRQ_HI   = 8'hFF;

    // One-hot low-byte presets {FE,FD,FC,FB,FA}. $FF needs no preset: the
    // precharged low-byte bus already reads all ones, so its code is 0.
    localparam logic [4:0] ADL_FA = 5'b00001;
    localparam logic [4:0] ADL_FB = 5'b00010;
    localparam logic [4:0] ADL_FC = 5'b00100;
    localparam logic [4:0] ADL_FD = 5'b01000;
    localparam logic [4:0] ADL_FE = 5'b10000;
    localparam logic [4:0] ADL_FF = 5'b00000;

    function automatic logic [7:0] vec_lo(input vec_kind_t kind);
        case (kind)
            VK_NMI:   return VEC_NMI_LO;
            VK_RESET: return VEC_RESET_LO;
            default:  return VEC_IRQ_LO;
        endcase
    endfunction

    function automatic logic [7:0] vec_hi(input vec_kind_t kind);
        case (kind)
            VK_NMI:   return VEC_NMI_HI;
            VK_RESET: return VEC_RESET_HI;
            default:  return VEC_IRQ_HI;
        endcase
    endfunction

    function automatic logic [4:0] adl_code(input logic [7:0] vec);
        case (vec)
            8'hFA:   return ADL_FA;
            8'hFB:   return ADL_FB;
            8'hFC:   return ADL_FC;
            8'hFD:   return ADL_FD;
            8'hFE:   return ADL_FE;
            default: return ADL_FF;
        endcase
    endfunction

endpackage

// File: rtl/vector_fetch_sequencer_nmi_edge_detector.sv
// rtl/vector_fetch_sequencer_nmi_edge_detector.sv - NMI rising-edge detector with clearable pending flag
module nmi_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic nmi_req,
    input  logic clr,
    output logic pending
);

    logic nmi_prev;
    logic pending_q;
    logic rise;

    // A fresh edge is visible as pending in the cycle it arrives, so an NMI
    // raised together with another request still wins priority.
    assign rise    = nmi_req & ~nmi_prev;
    assign pending = pending_q | rise;

    // Sample the line and hold the pending flag; when the served request is an
    // older edge and a new edge lands in the same cycle, the new edge survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_prev  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            nmi_prev  <= nmi_req;
            pending_q <= clr ? (pending_q & rise) : (pending_q | rise);
        end
    end

endmodule

// File: rtl/vector_fetch_sequencer.sv
// rtl/vector_fetch_sequencer.sv - fetches the RESET/NMI/IRQ/BRK vector in two beats and loads the PC
module vector_fetch_sequencer
    import vfs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reset_req,
    input  logic        nmi_req,
    input  logic        irq_req,
    input  logic        brk_req,
    input  logic        irq_mask,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [4:0]  adl_sel,
    output logic        adh_ff,
    output logic        mem_req,
    output logic [15:0] pc_out,
    output logic        pc_load,
    output logic        set_i_flag,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t    state;
    vec_kind_t kind;
    vec_kind_t sel_kind;
    logic [7:0] tcnt;
    logic       nmi_pending;
    logic       brk_pending;
    logic       accept;
    logic       nmi_clr;
    logic       brk_irq_acc;

    nmi_edge_detector u_nmi (
        .clk     (clk),
        .rst     (rst),
        .nmi_req (nmi_req),
        .clr     (nmi_clr),
        .pending (nmi_pending)
    );

    // Priority select among the requests, only meaningful while idle.
    always_comb begin
        accept      = 1'b1;
        sel_kind    = VK_RESET;
        nmi_clr     = 1'b0;
        brk_irq_acc = 1'b0;
        if (reset_req) begin
            sel_kind = VK_RESET;
        end else if (nmi_pending) begin
            sel_kind = VK_NMI;
            nmi_clr  = 1'b1;
        end else if (brk_pending || (irq_req && !irq_mask)) begin
            sel_kind    = VK_IRQ;
            brk_irq_acc = 1'b1;
        end else begin
            accept = 1'b0;
        end
        if (state != IDLE) begin
            accept      = 1'b0;
            nmi_clr     = 1'b0;
            brk_irq_acc = 1'b0;
        end
    end

    // Sequencer: beat handshake, PC capture, abort-to-reset and beat timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            kind        <= VK_RESET;
            adl_sel     <= 5'd0;
            adh_ff      <= 1'b0;
            mem_req     <= 1'b0;
            pc_out      <= 16'd0;
            pc_load     <= 1'b0;
            set_i_flag  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            tcnt        <= 8'd0;
            brk_pending <= 1'b0;
        end else begin
            pc_load    <= 1'b0;
            set_i_flag <= 1'b0;

            if (brk_req) begin
                brk_pending <= 1'b1;
            end else if (brk_irq_acc) begin
                brk_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        kind        <= sel_kind;
                        state       <= FETCH_LO;
                        mem_req     <= 1'b1;
                        adh_ff      <= 1'b1;
                        adl_sel     <= adl_code(vec_lo(sel_kind));
                        busy        <= 1'b1;
                        tcnt        <= 8'd0;
                        timeout_err <= 1'b0;
                    end
                end
                FETCH_LO, FETCH_HI: begin
                    if (reset_req && kind != VK_RESET) begin
                        state   <= ABORT;
                        mem_req <= 1'b0;
                        adh_ff  <= 1'b0;
                        adl_sel <= 5'd0;
                    end else if (mem_ack) begin
                        tcnt <= 8'd0;
                        if (state == FETCH_LO) begin
                            pc_out[7:0] <= mem_data;
                            state       <= FETCH_HI;
                            adl_sel     <= adl_code(vec_hi(kind));
                        end else begin
                            pc_out[15:8] <= mem_data;
                            state        <= DONE;
                            mem_req      <= 1'b0;
                            adh_ff       <= 1'b0;
                            adl_sel      <= 5'd0;
                            pc_load      <= 1'b1;
                            set_i_flag   <= 1'b1;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        mem_req     <= 1'b0;
                        adh_ff      <= 1'b0;
                        adl_sel     <= 5'd0;
                        tcnt        <= 8'd0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ABORT: begin
                    kind    <= VK_RESET;
                    state   <= FETCH_LO;
                    mem_req <= 1'b1;
                    adh_ff  <= 1'b1;
                    adl_sel <= adl_code(VEC_RESET_LO);
                    tcnt    <= 8'd0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
